// File: rtl/timer_preset_loader.sv
// Keypad-side preset writer for the M:SS countdown chain: collects digits, validates them,
// issues a one-cycle active-low load and gates the 1 Hz count enable until the chain reads 0:00.
module timer_preset_loader #(
    parameter int SEC_TENS_MAX = 5,
    parameter int DONE_HOLD    = 4
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop,
    input  logic       tick,
    input  logic       timer_zero,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       loadn,
    output logic       enable,
    output logic [1:0] ndigits,
    output logic       entry_err,
    output logic       running,
    output logic       done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENTRY  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_PAUSE  = 3'd4;
    localparam logic [2:0] S_CANCEL = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [3:0] TENS_MAX  = 4'(SEC_TENS_MAX);
    localparam logic [3:0] HOLD_LAST = 4'(DONE_HOLD - 1);

    logic [2:0] state;
    logic [3:0] hold_cnt;
    logic       all_zero;

    assign all_zero = ({min_ones, sec_tens, sec_ones} == 12'd0);

    // CANCEL drives the zeroed digits through the same load path to clear the chain.
    assign loadn   = !((state == S_LOAD) || (state == S_CANCEL));
    assign enable  = (state == S_RUN) && tick && !timer_zero;
    assign running = (state == S_RUN);
    assign done    = (state == S_DONE);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state     <= S_IDLE;
            min_ones  <= 4'd0;
            sec_tens  <= 4'd0;
            sec_ones  <= 4'd0;
            ndigits   <= 2'd0;
            entry_err <= 1'b0;
            hold_cnt  <= 4'd0;
        end else begin
            entry_err <= 1'b0;
            case (state)
                S_IDLE, S_ENTRY: begin
                    if (stop) begin
                        state    <= S_IDLE;
                        min_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        sec_ones <= 4'd0;
                        ndigits  <= 2'd0;
                    end else if ((state == S_ENTRY) && start) begin
                        // start judges the pre-shift digits; a coincident key is dropped
                        if (sec_tens > TENS_MAX) begin
                            entry_err <= 1'b1;
                        end else if (!all_zero) begin
                            state <= S_LOAD;
                        end
                    end else if (key_valid) begin
                        if (key_code <= 4'd9) begin
                            min_ones <= sec_tens;
                            sec_tens <= sec_ones;
                            sec_ones <= key_code;
                            ndigits  <= (ndigits == 2'd3) ? 2'd3 : ndigits + 2'd1;
                            state    <= S_ENTRY;
                        end else begin
                            entry_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: state <= S_RUN;
                S_RUN: begin
                    if (timer_zero) begin
                        state    <= S_DONE;
                        hold_cnt <= 4'd0;
                    end else if (stop) begin
                        state <= S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        state    <= S_CANCEL;
                        min_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        sec_ones <= 4'd0;
                        ndigits  <= 2'd0;
                    end else if (start) begin
                        state <= S_RUN;
                    end
                end
                S_CANCEL: state <= S_IDLE;
                S_DONE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= S_IDLE;
                        min_ones <= 4'd0;
                        sec_tens <= 4'd0;
                        sec_ones <= 4'd0;
                        ndigits  <= 2'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
